// File: rtl/cc_viterbi_dec.sv
// Hard-decision Viterbi decoder, rate-1/2 K=7 (G1=171o, G2=133o), 64 ACS units, register-exchange survivors.
// Define CC_VITERBI_ZERO_TAIL_EN to flush from state 0 (zero-terminated frames) instead of the best state.
module cc_viterbi_dec #(
    parameter int unsigned TB_LEN = 32,
    parameter int unsigned PM_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sym_in,
    input  logic       valid_in,
    input  logic       last_in,
    output logic       ready_in,
    output logic       bit_out,
    output logic       valid_out,
    output logic       last_out
);

    localparam int unsigned NS    = 64;
    localparam int unsigned CNT_W = $clog2(TB_LEN + 1);
    localparam int unsigned IDX_W = $clog2(TB_LEN);

    localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(1) << (PM_W - 3);
    localparam logic [PM_W-1:0]  MSB_MASK = PM_W'(1) << (PM_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TB_LEN);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SNAP,
        ST_DRAIN
    } state_t;

    // Encoder output {y,x} for leaving state s with input bit b.
    function automatic logic [1:0] exp_sym(input logic [5:0] s, input logic b);
        logic x;
        logic y;
        x = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
        y = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
        return {y, x};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[0]} + {1'b0, d[1]};
    endfunction

    state_t              state_q, state_d;
    logic [PM_W-1:0]     pm_q   [NS];
    logic [PM_W-1:0]     pm_d   [NS];
    logic [TB_LEN-1:0]   path_q [NS];
    logic [TB_LEN-1:0]   path_d [NS];
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    f_q, f_d;
    logic [TB_LEN-1:0]   flush_q, flush_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                bit_out_q, bit_out_d;
    logic                valid_out_q, valid_out_d;
    logic                last_out_q, last_out_d;
    logic                ready_in_q, ready_in_d;

    logic [PM_W-1:0]     acs_raw  [NS];
    logic [PM_W-1:0]     acs_pm   [NS];
    logic [TB_LEN-1:0]   acs_path [NS];
    logic                all_msb;
    logic [5:0]          ns, pa0, pa1;
    logic [PM_W-1:0]     c0, c1;
    logic [5:0]          best_idx;
    logic [PM_W-1:0]     best_pm;
    logic [5:0]          tail_idx;
    logic [TB_LEN-1:0]   tail_path;

    // Add-compare-select for all 64 states; ties keep the a=0 predecessor.
    always_comb begin
        all_msb = 1'b1;
        ns      = '0;
        pa0     = '0;
        pa1     = '0;
        c0      = '0;
        c1      = '0;
        for (int n = 0; n < NS; n++) begin
            ns  = 6'(n);
            pa0 = {1'b0, ns[5:1]};
            pa1 = {1'b1, ns[5:1]};
            c0  = pm_q[pa0] + PM_W'(hamming2(sym_in, exp_sym(pa0, ns[0])));
            c1  = pm_q[pa1] + PM_W'(hamming2(sym_in, exp_sym(pa1, ns[0])));
            if (c1 < c0) begin
                acs_raw[n]  = c1;
                acs_path[n] = {path_q[pa1][TB_LEN-2:0], ns[0]};
            end else begin
                acs_raw[n]  = c0;
                acs_path[n] = {path_q[pa0][TB_LEN-2:0], ns[0]};
            end
            all_msb = all_msb & acs_raw[n][PM_W-1];
        end
    end

    // Renormalise by clearing the shared MSB once every metric has crossed it.
    always_comb begin
        for (int n = 0; n < NS; n++) begin
            acs_pm[n] = all_msb ? (acs_raw[n] ^ MSB_MASK) : acs_raw[n];
        end
    end

    // Best state from the registered metrics, lowest index wins ties.
    always_comb begin
        best_idx = '0;
        best_pm  = pm_q[0];
        for (int n = 1; n < NS; n++) begin
            if (pm_q[n] < best_pm) begin
                best_pm  = pm_q[n];
                best_idx = 6'(n);
            end
        end
    end

`ifdef CC_VITERBI_ZERO_TAIL_EN
    assign tail_idx = '0;
`else
    assign tail_idx = best_idx;
`endif

    assign tail_path = path_q[tail_idx];

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        pm_d        = pm_q;
        path_d      = path_q;
        count_d     = count_q;
        f_d         = f_q;
        flush_d     = flush_q;
        idx_d       = idx_q;
        bit_out_d   = 1'b0;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (valid_in) begin
                    pm_d    = acs_pm;
                    path_d  = acs_path;
                    count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
                    if (count_q == CNT_MAX) begin
                        bit_out_d   = path_q[best_idx][TB_LEN-1];
                        valid_out_d = 1'b1;
                    end
                    if (last_in) begin
                        f_d     = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
                        state_d = ST_SNAP;
                    end
                end
            end
            ST_SNAP: begin
                // Capture the tail survivor, emit its oldest bit, and reinitialise the trellis.
                flush_d     = tail_path;
                bit_out_d   = tail_path[IDX_W'(f_q - CNT_W'(1))];
                valid_out_d = 1'b1;
                for (int n = 0; n < NS; n++) begin
                    pm_d[n]   = (n == 0) ? '0 : PM_INIT;
                    path_d[n] = '0;
                end
                count_d = '0;
                if (f_q == CNT_W'(1)) begin
                    last_out_d = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    idx_d   = IDX_W'(f_q - CNT_W'(2));
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bit_out_d   = flush_q[idx_q];
                valid_out_d = 1'b1;
                if (idx_q == '0) begin
                    last_out_d = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        ready_in_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            for (int n = 0; n < NS; n++) begin
                pm_q[n]   <= (n == 0) ? '0 : PM_INIT;
                path_q[n] <= '0;
            end
            count_q     <= '0;
            f_q         <= '0;
            flush_q     <= '0;
            idx_q       <= '0;
            bit_out_q   <= 1'b0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            ready_in_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pm_q        <= pm_d;
            path_q      <= path_d;
            count_q     <= count_d;
            f_q         <= f_d;
            flush_q     <= flush_d;
            idx_q       <= idx_d;
            bit_out_q   <= bit_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
            ready_in_q  <= ready_in_d;
        end
    end

    assign ready_in  = ready_in_q;
    assign bit_out   = bit_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;

endmodule

// File: tb/tb_cc_viterbi_dec.sv
// Bench for cc_viterbi_dec: table of frames encoded locally, decoded bits compared to the payload.
module tb_cc_viterbi_dec;

    localparam int TB_LEN = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sym_in;
    logic       valid_in;
    logic       last_in;
    logic       ready_in;
    logic       bit_out;
    logic       valid_out;
    logic       last_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int stray_last = 0;

    logic out_bits[$];
    logic out_last[$];
    int   out_cyc[$];
    int   acc_cyc[$];

    typedef struct {
        int         n;
        logic [7:0] pat;
        int         e0;
        int         e1;
        int         e2;
        bit         junk;
        bit         tailz;
        int         exp_low;
    } frame_t;

    frame_t tbl[8];

    cc_viterbi_dec #(.TB_LEN(TB_LEN), .PM_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_in    (sym_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .bit_out   (bit_out),
        .valid_out (valid_out),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            out_bits.push_back(bit_out);
            out_last.push_back(last_out);
            out_cyc.push_back(cyc);
        end
        if (!reset && last_out && !valid_out) stray_last++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input frame_t f, input int i);
        logic [7:0] p;
        p = f.pat;
        if (f.tailz && i >= f.n - 6) return 1'b0;
        return p[i % 8];
    endfunction

    // Encode and drive symbols 0..stop_at-1 back to back; returns at the negedge after the last accept.
    task automatic drive_syms(input frame_t f, input int stop_at);
        logic [5:0] s;
        logic       b, x, y;
        logic [1:0] sy;
        bit         rdy;
        int         tries;
        s = '0;
        @(negedge clk);
        for (int k = 0; k < stop_at; k++) begin
            b  = exp_bit(f, k);
            x  = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
            y  = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
            s  = {s[4:0], b};
            sy = {y, x};
            if (k == f.e0 || k == f.e1 || k == f.e2) sy[0] = ~sy[0];
            sym_in   = sy;
            valid_in = 1'b1;
            last_in  = (k == f.n - 1);
            tries    = 0;
            do begin
                rdy = ready_in;
                @(negedge clk);
                tries++;
            end while (!rdy && tries < 50);
            if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
            acc_cyc.push_back(cyc);
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic clear_mon();
        out_bits.delete();
        out_last.delete();
        out_cyc.delete();
        acc_cyc.delete();
        stray_last = 0;
    endtask

    task automatic run_frame(input frame_t f, input string tag);
        int low;
        bit done;
        int lim;
        clear_mon();
        drive_syms(f, f.n);
        low  = 0;
        done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            #1;
            if (!ready_in) low++;
            if (ready_in && out_bits.size() >= f.n) done = 1;
            valid_in = f.junk && !ready_in;
            last_in  = valid_in;
            sym_in   = 2'($urandom);
            if (!done) @(negedge clk);
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_nbits"}, 32'(out_bits.size()), 32'(f.n));
        lim = (out_bits.size() < f.n) ? out_bits.size() : f.n;
        for (int i = 0; i < lim; i++) begin
            check($sformatf("%s_bit%0d", tag, i), 32'(out_bits[i]), 32'(exp_bit(f, i)));
            check($sformatf("%s_last%0d", tag, i), 32'(out_last[i]), 32'(i == f.n - 1));
        end
        if (f.n > TB_LEN && out_cyc.size() > 0)
            check({tag, "_latency"}, 32'(out_cyc[0]), 32'(acc_cyc[TB_LEN]));
        if (f.exp_low >= 0)
            check({tag, "_ready_low"}, 32'(low), 32'(f.exp_low));
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_no_extra"}, 32'(out_bits.size()), 32'(f.n));
        check({tag, "_stray_last"}, 32'(stray_last), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fr;
        int     nl;

        tbl[0] = '{100, 8'hB5, -1, -1, -1, 1'b0, 1'b0, 32};
        tbl[1] = '{100, 8'hB5, 10, 50, 90, 1'b0, 1'b0, -1};
        tbl[2] = '{5,   8'h0D, -1, -1, -1, 1'b0, 1'b0, 5};
        tbl[3] = '{20,  8'h5A, -1, -1, -1, 1'b1, 1'b0, 20};
        tbl[4] = '{64,  8'h3C, -1, -1, -1, 1'b0, 1'b1, -1};
        tbl[5] = '{1,   8'h01, -1, -1, -1, 1'b0, 1'b0, 1};
        tbl[6] = '{32,  8'hE7, -1, -1, -1, 1'b0, 1'b0, -1};
        tbl[7] = '{33,  8'h96, -1, -1, -1, 1'b1, 1'b0, 32};

        reset    = 1'b1;
        sym_in   = '0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bit_out", 32'(bit_out), 32'd0);
        check("rst_ready", 32'(ready_in), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle%0d_valid", i), 32'(valid_out), 32'd0);
            check($sformatf("idle%0d_last", i), 32'(last_out), 32'd0);
            check($sformatf("idle%0d_ready", i), 32'(ready_in), 32'd1);
        end

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i], $sformatf("f%0d", i));
        end

        // Reset in the middle of a 100-symbol frame.
        clear_mon();
        fr = '{100, 8'hB5, -1, -1, -1, 1'b0, 1'b0, -1};
        drive_syms(fr, 40);
        #1;
        check("mid_nbits", 32'(out_bits.size()), 32'd8);
        for (int i = 0; i < 8 && i < out_bits.size(); i++)
            check($sformatf("mid_bit%0d", i), 32'(out_bits[i]), 32'(exp_bit(fr, i)));
        nl = 0;
        foreach (out_last[i]) if (out_last[i]) nl++;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_last", 32'(last_out), 32'd0);
        check("mid_rst_ready", 32'(ready_in), 32'd1);
        check("mid_rst_bit", 32'(bit_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_no_last", 32'(nl + stray_last), 32'd0);
        check("mid_quiet", 32'(out_bits.size()), 32'd8);

        fr = '{64, 8'hC9, -1, -1, -1, 1'b0, 1'b0, 32};
        run_frame(fr, "post_rst");
        fr = '{64, 8'hC9, -1, -1, -1, 1'b0, 1'b1, 32};
        run_frame(fr, "post_rst_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
